bcd_display_scan: RTL and testbench

Multiplexed 7-segment display driver that sits directly downstream of the binary-to-BCD converter. It latches a packed BCD word on a load strobe and time-multiplexes its digits onto one shared active-low segment bus, one anode at a time. It provides inter-digit blanking against ghosting, optional leading-zero suppression, and an invalid-digit flag.

---
 rtl/bcd_display_scan_if.sv | 22 ++
 rtl/bcd_display_scan.sv | 111 +++++++++++
 tb/tb_bcd_display_scan.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/bcd_display_scan_if.sv
// Bus bundle between the BCD source and the multiplexed 7-segment driver.
// The master supplies the packed BCD word and controls; the slave returns the display drive.
interface bcd_display_scan_if #(
   parameter int NUM_DIGITS = 2
);
   logic [4*NUM_DIGITS-1:0] bcd_in;
   logic                    bcd_load;
   logic                    lzb_en;
   logic [6:0]              seg;
   logic [NUM_DIGITS-1:0]   an;
   logic                    bcd_err;

   modport master (
      output bcd_in, bcd_load, lzb_en,
      input  seg, an, bcd_err
   );

   modport slave (
      input  bcd_in, bcd_load, lzb_en,
      output seg, an, bcd_err
   );
endinterface

// File: rtl/bcd_display_scan.sv
// Multiplexed 7-segment driver: latches a packed BCD word and scans its digits onto an
// active-low segment bus, with inter-digit blanking, leading-zero blanking and an invalid-digit flag.
module bcd_display_scan #(
   parameter int NUM_DIGITS = 2,
   parameter int CLK_DIV    = 50000,
   parameter int BLANK_CYC  = 2
) (
   input logic               clk,
   input logic               rst_n,
   bcd_display_scan_if.slave bus
);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int PW    = $clog2(CLK_DIV);
   localparam int DW    = 4 * NUM_DIGITS;

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h3F;
      endcase
      return s;
   endfunction

   logic [DW-1:0]         shadow_q, shadow_d;
   logic [PW-1:0]         presc_q, presc_d;
   logic [PW-1:0]         blank_q, blank_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [6:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic                  err_q, err_d;
   logic                  tick;
   logic [3:0]            cur_nib;
   logic                  cur_lz;
   logic                  zero_above;

   always_comb begin
      tick       = (presc_q == PW'(CLK_DIV - 1));
      shadow_d   = bus.bcd_load ? bus.bcd_in : shadow_q;
      presc_d    = tick ? '0 : presc_q + PW'(1);
      idx_d      = idx_q;
      blank_d    = '0;
      cur_nib    = '0;
      cur_lz     = 1'b0;
      zero_above = 1'b1;
      err_d      = 1'b0;
      an_d       = '1;

      if (tick) begin
         idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end

      if (tick) begin
         blank_d = PW'(BLANK_CYC);
      end else if (blank_q != '0) begin
         blank_d = blank_q - PW'(1);
      end

      // Walk from the most significant digit down so zero_above covers nibble i and everything above it.
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above && (shadow_q[4*i +: 4] == 4'd0);
         err_d      = err_d | (shadow_q[4*i +: 4] > 4'd9);
         if (idx_q == IDX_W'(i)) begin
            cur_nib = shadow_q[4*i +: 4];
            cur_lz  = zero_above && (i != 0);
         end
      end

      if (blank_q == '0) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            an_d[i] = (idx_q != IDX_W'(i));
         end
      end

      // A suppressed leading zero still gets its anode slot; only the segments go dark.
      seg_d = (bus.lzb_en && cur_lz) ? 7'h7F : seg_decode(cur_nib);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shadow_q <= '0;
         presc_q  <= '0;
         blank_q  <= '0;
         idx_q    <= '0;
         seg_q    <= 7'h7F;
         an_q     <= '1;
         err_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         presc_q  <= presc_d;
         blank_q  <= blank_d;
         idx_q    <= idx_d;
         seg_q    <= seg_d;
         an_q     <= an_d;
         err_q    <= err_d;
      end
   end

   assign bus.seg     = seg_q;
   assign bus.an      = an_q;
   assign bus.bcd_err = err_q;
endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with a short scan (2 digits, 4-cycle slots, 1 blank cycle).
module tb_bcd_display_scan;
   localparam int N  = 2;
   localparam int CD = 4;
   localparam int BC = 1;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   k     = 0;

   always #5 clk = ~clk;

   bcd_display_scan_if #(.NUM_DIGITS(N)) bus ();

   bcd_display_scan #(
      .NUM_DIGITS(N),
      .CLK_DIV   (CD),
      .BLANK_CYC (BC)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s (edge %0d): got %0h expected %0h", tag, k, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         k++;
      end
   endtask

   task automatic run_to(input int target);
      while (k < target) step(1);
   endtask

   // Expected anode pattern k edges after reset release: first slot is 4 unblanked digit-0
   // cycles, then an 8-cycle frame of blank, digit 1 x3, blank, digit 0 x3.
   function automatic logic [1:0] exp_an(input int kk);
      int p;
      if (kk <= 4) return 2'b10;
      p = (kk - 5) % 8;
      if (p == 0 || p == 4) return 2'b11;
      if (p < 4) return 2'b01;
      return 2'b10;
   endfunction

   task automatic do_reset(input string tag);
      rst_n        = 1'b0;
      bus.bcd_load = 1'b0;
      bus.bcd_in   = '0;
      step(3);
      chk({tag, "_rst_seg"}, bus.seg, 7'h7F);
      chk({tag, "_rst_an"}, bus.an, 2'b11);
      chk({tag, "_rst_err"}, bus.bcd_err, 1'b0);
      rst_n = 1'b1;
      k     = 0;
   endtask

   task automatic load(input logic [7:0] v);
      bus.bcd_in   = v;
      bus.bcd_load = 1'b1;
      step(1);
      bus.bcd_load = 1'b0;
   endtask

   initial begin
      bus.lzb_en   = 1'b0;
      bus.bcd_in   = '0;
      bus.bcd_load = 1'b0;
      rst_n        = 1'b0;

      // Reset and hold, then the first released cycle still shows reset values
      do_reset("init");
      chk("release_seg", bus.seg, 7'h7F);
      chk("release_an", bus.an, 2'b11);
      chk("release_err", bus.bcd_err, 1'b0);

      // Scan pattern with 0x42: digit 0 = 2 (24), digit 1 = 4 (19)
      load(8'h42);
      chk("first_slot_old_shadow", bus.seg, 7'h40);
      chk("first_slot_an", bus.an, 2'b10);
      for (int kk = 2; kk <= 20; kk++) begin
         run_to(kk);
         chk("scan_an", bus.an, exp_an(kk));
         if (exp_an(kk) == 2'b10) chk("scan_seg_d0", bus.seg, 7'h24);
         if (exp_an(kk) == 2'b01) chk("scan_seg_d1", bus.seg, 7'h19);
         chk("scan_err", bus.bcd_err, 1'b0);
      end

      // Leading-zero blanking with 0x07
      do_reset("lzb");
      bus.lzb_en = 1'b1;
      load(8'h07);
      run_to(6);
      chk("lzb_d1_an", bus.an, 2'b01);
      chk("lzb_d1_blank", bus.seg, 7'h7F);
      run_to(10);
      chk("lzb_d0_an", bus.an, 2'b10);
      chk("lzb_d0_seg", bus.seg, 7'h78);
      bus.lzb_en = 1'b0;
      run_to(14);
      chk("nolzb_d1_an", bus.an, 2'b01);
      chk("nolzb_d1_seg", bus.seg, 7'h40);
      bus.lzb_en = 1'b1;
      load(8'h00);
      run_to(16);
      chk("lzb00_d1_seg", bus.seg, 7'h7F);
      run_to(18);
      chk("lzb00_d0_an", bus.an, 2'b10);
      chk("lzb00_d0_seg", bus.seg, 7'h40);
      bus.lzb_en = 1'b0;

      // Invalid digit 0x3C, then cleared by 0x39
      do_reset("err");
      load(8'h3C);
      chk("err_lag", bus.bcd_err, 1'b0);
      step(1);
      chk("err_set", bus.bcd_err, 1'b1);
      chk("err_dash_d0", bus.seg, 7'h3F);
      run_to(6);
      chk("err_d1_seg", bus.seg, 7'h30);
      load(8'h39);
      chk("err_still_set", bus.bcd_err, 1'b1);
      step(1);
      chk("err_cleared", bus.bcd_err, 1'b0);
      run_to(10);
      chk("err_d0_nine", bus.seg, 7'h10);

      // Load coinciding with the tick that moves idx 0 -> 1
      do_reset("coll");
      run_to(3);
      chk("coll_pre_seg", bus.seg, 7'h40);
      load(8'h95);
      chk("coll_d0_last", bus.an, 2'b10);
      step(1);
      chk("coll_blank_an", bus.an, 2'b11);
      for (int kk = 6; kk <= 8; kk++) begin
         run_to(kk);
         chk("coll_d1_an", bus.an, 2'b01);
         chk("coll_d1_seg", bus.seg, 7'h10);
      end
      run_to(10);
      chk("coll_d0_seg", bus.seg, 7'h12);

      // Reset during the digit-1 blank cycle, with a competing load
      run_to(12);
      rst_n        = 1'b0;
      bus.bcd_in   = 8'h88;
      bus.bcd_load = 1'b1;
      step(1);
      chk("midrst_an", bus.an, 2'b11);
      chk("midrst_seg", bus.seg, 7'h7F);
      chk("midrst_err", bus.bcd_err, 1'b0);
      rst_n        = 1'b1;
      bus.bcd_load = 1'b0;
      k            = 0;
      for (int kk = 1; kk <= 4; kk++) begin
         run_to(kk);
         chk("midrst_d0_an", bus.an, 2'b10);
         chk("midrst_d0_seg", bus.seg, 7'h40);
      end
      run_to(5);
      chk("midrst_blank_an", bus.an, 2'b11);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
